price_level_book: RTL and testbench
===================================

# price_level_book

Aggregated-quantity limit order book: one quantity register per side per price level, with best-bid/best-ask tracking and an aggressive-order matching engine that emits one fill per cycle. It is the parametrised successor of the queue-based order book. It replaces per-order queues with per-level totals, and adds price-walking across levels, limit-price crossing checks and partial-fill reporting. It sits between the order-entry decoder and the fill/market-data publishers.

## Interface
Parameters:
- PRICE_LEVELS, 256, number of price ticks per side (≥2)
- PRICE_WIDTH, $clog2(PRICE_LEVELS), price index width
- QTY_WIDTH, 32, quantity width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid & in_ready; high only in IDLE
- in_op  in  2  00=add, 01=cancel, 10=match, 11=reserved
- in_side  in  1  0=bid/buy, 1=ask/sell (match: aggressor side)
- in_price  in  PRICE_WIDTH  level (match: limit price)
- in_qty  in  QTY_WIDTH  quantity
- fill_valid  out  1  one-cycle fill pulse
- fill_price  out  PRICE_WIDTH  level filled
- fill_qty  out  QTY_WIDTH  quantity filled
- done_valid  out  1  one-cycle match-complete pulse
- done_remain  out  QTY_WIDTH  unfilled aggressor quantity
- best_bid, best_ask  out  PRICE_WIDTH  best levels
- best_bid_valid, best_ask_valid  out  1  side non-empty
- err  out  1  one-cycle error pulse

## Operation
- States: IDLE, MATCH, SCAN. SCAN carries a return flag: go to MATCH if the aggressor still has quantity, else go to IDLE.
- Add (IDLE): qty[side][price] += in_qty, saturating at all-ones. Saturation pulses err. If the level becomes better than the current best, or the side was empty, best updates to that level. Bid: higher is better. Ask: lower is better.
- Cancel (IDLE): qty -= in_qty. If in_qty > level, the level clears to 0 and err pulses.
  - If a non-best level empties, best is unchanged and the FSM stays in IDLE.
  - If the best level empties, the FSM enters SCAN (return to IDLE).
- SCAN: examines one level per cycle, starting at old best ∓1 toward worse prices.
  - At the first non-zero level, best is set to that level.
  - If it passes index 0 (bids) or PRICE_LEVELS-1 (asks), best_valid is set to 0.
- Match (IDLE): rem ← in_qty; enter MATCH against the opposite side.
  - A buy crosses when best_ask ≤ limit. A sell crosses when best_bid ≥ limit.
- Each MATCH cycle:
  - If rem==0, the opposite side is empty, or the best level does not cross: pulse done_valid with done_remain=rem; go to IDLE.
  - Otherwise f = min(rem, level). Then level -= f and rem -= f, and fill_valid pulses with fill_price=best and fill_qty=f.
  - If rem reaches 0, done_valid (remain 0) pulses together with that fill.
  - If the level drained: enter SCAN, returning to MATCH if rem>0, else to IDLE.
  - If the level did not drain and rem==0: go to IDLE.
- Unfilled remainder is never rested; the caller decides.
- Zero-quantity add/cancel: no state change, no err. Match with qty 0: done_valid with remain 0 and no fills.
- Op 11: err pulses; no state change.
- All arithmetic is unsigned QTY_WIDTH. The min/subtract never underflow.

## Timing
- Reset values:
  - All qty 0; state IDLE; in_ready 1.
  - fill_valid, done_valid, err 0; fill_price, fill_qty, done_remain 0.
  - best_bid, best_ask 0; best_*_valid 0.
- Reset mid-MATCH or mid-SCAN aborts the operation. No done_valid is produced.
- in_ready is combinational (state==IDLE). in_valid while in_ready=0 is ignored; the source holds the command.
- Add/cancel: accepted at edge N. qty and best are visible after edge N; err pulses in the cycle after N.
- Match: accepted at edge N. First fill or done_valid is registered at edge N+1.
- Each level drain adds SCAN cycles equal to the number of empty levels walked plus 1.
- fill_*, done_*, err are registered and valid for exactly one cycle.
- No back-pressure on fill/done outputs.

## Test plan
- Reset, then add bid p100 q5 -> next cycle best_bid=100, best_bid_valid=1, best_ask_valid=0, in_ready=1.
- Bid p100 q5 and p98 q10; match sell limit 99 q8 -> fill (100,5), SCAN walks 99 then finds 98, best_bid=98, then done_valid remain 3 with no further fill.
- Ask p50 q4 and p51 q4; match buy limit 60 q6 -> fill (50,4), then fill (51,2) with done_valid remain 0 in the same cycle; best_ask=51, level 51 holds 2.
- Cancel bid p100 q7 when level holds 5 -> err pulse, level 0, SCAN to best_bid_valid=0 when no other bids exist; in_ready low during scan.
- Add ask p10 with in_qty all-ones twice -> second add pulses err, level stays all-ones. Op 11 -> err only.
- Assert reset during MATCH -> all outputs return to reset values immediately, no done_valid; the book is empty after release.

Source files
------------

// File: rtl/price_level_book.sv
// Aggregated-quantity limit order book: per-level totals per side, best-price
// tracking, and an aggressive-order matcher that emits one fill per cycle.
module price_level_book #(
    parameter int PRICE_LEVELS = 256,
    parameter int PRICE_WIDTH  = $clog2(PRICE_LEVELS),
    parameter int QTY_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic                   in_side,
    input  logic [PRICE_WIDTH-1:0] in_price,
    input  logic [QTY_WIDTH-1:0]   in_qty,
    output logic                   fill_valid,
    output logic [PRICE_WIDTH-1:0] fill_price,
    output logic [QTY_WIDTH-1:0]   fill_qty,
    output logic                   done_valid,
    output logic [QTY_WIDTH-1:0]   done_remain,
    output logic [PRICE_WIDTH-1:0] best_bid,
    output logic [PRICE_WIDTH-1:0] best_ask,
    output logic                   best_bid_valid,
    output logic                   best_ask_valid,
    output logic                   err
);
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CXL   = 2'b01;
    localparam logic [1:0] OP_MATCH = 2'b10;
    localparam logic [PRICE_WIDTH-1:0] P_MAX = PRICE_WIDTH'(PRICE_LEVELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MATCH, S_SCAN} state_t;
    state_t r_state, w_state_nx;

    logic [QTY_WIDTH-1:0]   r_qty [2][PRICE_LEVELS];
    logic [PRICE_WIDTH-1:0] r_best [2];
    logic [1:0]             r_bvld;
    logic [QTY_WIDTH-1:0]   r_rem;
    logic [PRICE_WIDTH-1:0] r_limit;
    logic                   r_side;
    logic                   r_ret;
    logic                   r_scan_side;
    logic                   r_scan_edge;
    logic [PRICE_WIDTH-1:0] r_scan_ptr;

    logic                   w_acc, w_sat, w_cxl_empty, w_cxl_best;
    logic                   w_opp, w_cross, w_mstop, w_drain;
    logic                   w_sedge, w_sdone, w_ss;
    logic [QTY_WIDTH-1:0]   w_lvl_in, w_olvl, w_f, w_rem_nx, w_slvl;
    logic [QTY_WIDTH:0]     w_sum;
    logic [PRICE_WIDTH-1:0] w_sb;

    assign in_ready       = (r_state == S_IDLE);
    assign best_bid       = r_best[0];
    assign best_ask       = r_best[1];
    assign best_bid_valid = r_bvld[0];
    assign best_ask_valid = r_bvld[1];

    assign w_acc       = in_valid && in_ready;
    assign w_lvl_in    = r_qty[in_side][in_price];
    assign w_sum       = {1'b0, w_lvl_in} + {1'b0, in_qty};
    assign w_sat       = w_sum[QTY_WIDTH];
    assign w_cxl_empty = (in_qty >= w_lvl_in);
    assign w_cxl_best  = w_acc && (in_op == OP_CXL) && (in_qty != '0) && w_cxl_empty &&
                         r_bvld[in_side] && (in_price == r_best[in_side]);

    // Matching always works against the side opposite the aggressor.
    assign w_opp    = ~r_side;
    assign w_olvl   = r_qty[w_opp][r_best[w_opp]];
    assign w_cross  = r_side ? (r_best[0] >= r_limit) : (r_best[1] <= r_limit);
    assign w_mstop  = (r_rem == '0) || !r_bvld[w_opp] || !w_cross;
    assign w_f      = (r_rem < w_olvl) ? r_rem : w_olvl;
    assign w_rem_nx = r_rem - w_f;
    assign w_drain  = (w_olvl == w_f);

    // Scan setup is shared by cancel (from IDLE) and level drain (from MATCH).
    assign w_ss    = (r_state == S_IDLE) ? in_side : w_opp;
    assign w_sb    = r_best[w_ss];
    assign w_slvl  = r_qty[r_scan_side][r_scan_ptr];
    assign w_sedge = r_scan_side ? (r_scan_ptr == P_MAX) : (r_scan_ptr == '0);
    assign w_sdone = r_scan_edge || (w_slvl != '0) || w_sedge;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc && in_op == OP_MATCH) w_state_nx = S_MATCH;
                else if (w_cxl_best)            w_state_nx = S_SCAN;
            end
            S_MATCH: begin
                if (w_mstop)      w_state_nx = S_IDLE;
                else if (w_drain) w_state_nx = S_SCAN;
                else              w_state_nx = S_IDLE;
            end
            S_SCAN:  if (w_sdone) w_state_nx = r_ret ? S_MATCH : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++)
                for (int p = 0; p < PRICE_LEVELS; p++) r_qty[s][p] <= '0;
            r_best[0]   <= '0;
            r_best[1]   <= '0;
            r_bvld      <= '0;
            r_rem       <= '0;
            r_limit     <= '0;
            r_side      <= 1'b0;
            r_ret       <= 1'b0;
            r_scan_side <= 1'b0;
            r_scan_edge <= 1'b0;
            r_scan_ptr  <= '0;
            fill_valid  <= 1'b0;
            fill_price  <= '0;
            fill_qty    <= '0;
            done_valid  <= 1'b0;
            done_remain <= '0;
            err         <= 1'b0;
        end else begin
            fill_valid <= 1'b0;
            done_valid <= 1'b0;
            err        <= 1'b0;
            if (w_state_nx == S_SCAN && r_state != S_SCAN) begin
                r_scan_side <= w_ss;
                r_scan_edge <= w_ss ? (w_sb == P_MAX) : (w_sb == '0);
                r_scan_ptr  <= w_ss ? w_sb + 1'b1 : w_sb - 1'b1;
                r_ret       <= (r_state == S_MATCH) && (w_rem_nx != '0);
            end
            case (r_state)
                S_IDLE: if (w_acc) begin
                    case (in_op)
                        OP_ADD: if (in_qty != '0) begin
                            r_qty[in_side][in_price] <= w_sat ? '1 : w_sum[QTY_WIDTH-1:0];
                            err <= w_sat;
                            if (!r_bvld[in_side] ||
                                (in_side ? (in_price < r_best[1]) : (in_price > r_best[0]))) begin
                                r_best[in_side] <= in_price;
                                r_bvld[in_side] <= 1'b1;
                            end
                        end
                        OP_CXL: if (in_qty != '0) begin
                            r_qty[in_side][in_price] <= w_cxl_empty ? '0 : w_lvl_in - in_qty;
                            err <= (in_qty > w_lvl_in);
                        end
                        OP_MATCH: begin
                            r_rem   <= in_qty;
                            r_limit <= in_price;
                            r_side  <= in_side;
                        end
                        default: err <= 1'b1;
                    endcase
                end
                S_MATCH: begin
                    if (w_mstop) begin
                        done_valid  <= 1'b1;
                        done_remain <= r_rem;
                    end else begin
                        r_qty[w_opp][r_best[w_opp]] <= w_olvl - w_f;
                        r_rem      <= w_rem_nx;
                        fill_valid <= 1'b1;
                        fill_price <= r_best[w_opp];
                        fill_qty   <= w_f;
                        if (w_rem_nx == '0) begin
                            done_valid  <= 1'b1;
                            done_remain <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_scan_edge || (w_slvl == '0 && w_sedge))
                        r_bvld[r_scan_side] <= 1'b0;
                    else if (w_slvl != '0)
                        r_best[r_scan_side] <= r_scan_ptr;
                    else
                        r_scan_ptr <= r_scan_side ? r_scan_ptr + 1'b1 : r_scan_ptr - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_price_level_book.sv
// Directed bench for price_level_book: book maintenance, matching, scans, errors, reset abort.
module tb_price_level_book;
    localparam int PW = 8;
    localparam int QW = 32;
    localparam logic [1:0] OP_ADD = 2'b00, OP_CXL = 2'b01, OP_MATCH = 2'b10, OP_RSV = 2'b11;

    logic          clk, reset, in_valid, in_ready, in_side;
    logic [1:0]    in_op;
    logic [PW-1:0] in_price, fill_price, best_bid, best_ask;
    logic [QW-1:0] in_qty, fill_qty, done_remain;
    logic          fill_valid, done_valid, best_bid_valid, best_ask_valid, err;

    price_level_book #(.PRICE_LEVELS(256), .PRICE_WIDTH(PW), .QTY_WIDTH(QW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_side(in_side), .in_price(in_price), .in_qty(in_qty),
        .fill_valid(fill_valid), .fill_price(fill_price), .fill_qty(fill_qty),
        .done_valid(done_valid), .done_remain(done_remain),
        .best_bid(best_bid), .best_ask(best_ask),
        .best_bid_valid(best_bid_valid), .best_ask_valid(best_ask_valid), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0, c0;
    int fp[$], fc[$], dc[$];
    longint fq[$], dr[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fill_valid) begin fp.push_back(fill_price); fq.push_back(fill_qty); fc.push_back(cyc); end
        if (done_valid) begin dr.push_back(done_remain); dc.push_back(cyc); end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        fp.delete(); fq.delete(); fc.delete(); dr.delete(); dc.delete();
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 1000) begin @(negedge clk); t++; end
        if (!in_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic cmd(input logic [1:0] op, input logic s, input logic [PW-1:0] p, input logic [QW-1:0] q);
        wait_idle();
        in_valid = 1'b1; in_op = op; in_side = s; in_price = p; in_qty = q;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 2'b00; in_qty = '0;
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (dr.size() < n && t < 500) begin @(negedge clk); #1; t++; end
        if (dr.size() < n) chk("done_timeout", dr.size(), n);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_side = 1'b0; in_price = '0; in_qty = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_bbv", best_bid_valid, 0);
        chk("rst_bav", best_ask_valid, 0);
        chk("rst_bb", best_bid, 0);
        chk("rst_ba", best_ask, 0);
        chk("rst_fill_qty", fill_qty, 0);
        chk("rst_done_remain", done_remain, 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);

        // first add sets best
        cmd(OP_ADD, 0, 100, 5);
        chk("add_bb", best_bid, 100);
        chk("add_bbv", best_bid_valid, 1);
        chk("add_bav", best_ask_valid, 0);
        chk("add_ready", in_ready, 1);
        chk("add_err", err, 0);

        // sell walks across an empty level and stops at a non-crossing one
        cmd(OP_ADD, 0, 98, 10);
        chk("worse_bid_keeps_best", best_bid, 100);
        clr_log();
        cmd(OP_MATCH, 1, 99, 8); c0 = cyc;
        wait_done(1); wait_idle();
        chk("m1_nfill", fp.size(), 1);
        chk("m1_fill_price", fp[0], 100);
        chk("m1_fill_qty", fq[0], 5);
        chk("m1_fill_lat", fc[0] - c0, 1);
        chk("m1_remain", dr[0], 3);
        chk("m1_done_lat", dc[0] - c0, 4);
        chk("m1_bb", best_bid, 98);
        cmd(OP_CXL, 0, 98, 10);
        chk("cxl_exact_err", err, 0);
        chk("cxl_scan_ready", in_ready, 0);
        wait_idle();
        chk("cxl_bbv", best_bid_valid, 0);

        // buy fills across two ask levels, done with the second fill
        cmd(OP_ADD, 1, 50, 4);
        cmd(OP_ADD, 1, 51, 4);
        chk("ask_ba", best_ask, 50);
        chk("ask_bav", best_ask_valid, 1);
        clr_log();
        cmd(OP_MATCH, 0, 60, 6);
        wait_done(1); wait_idle();
        chk("m2_nfill", fp.size(), 2);
        chk("m2_f0_price", fp[0], 50);
        chk("m2_f0_qty", fq[0], 4);
        chk("m2_f1_price", fp[1], 51);
        chk("m2_f1_qty", fq[1], 2);
        chk("m2_remain", dr[0], 0);
        chk("m2_done_with_fill", dc[0], fc[1]);
        chk("m2_ba", best_ask, 51);
        clr_log();
        cmd(OP_MATCH, 0, 60, 5);
        wait_done(1); wait_idle();
        chk("m3_nfill", fp.size(), 1);
        chk("m3_fill_qty", fq[0], 2);
        chk("m3_remain", dr[0], 3);
        chk("m3_bav", best_ask_valid, 0);
        clr_log();
        cmd(OP_MATCH, 0, 255, 7);
        wait_done(1);
        chk("m_empty_nfill", fp.size(), 0);
        chk("m_empty_remain", dr[0], 7);
        cmd(OP_ADD, 0, 30, 4);
        clr_log();
        cmd(OP_MATCH, 1, 0, 0);
        wait_done(1);
        chk("m_zero_nfill", fp.size(), 0);
        chk("m_zero_remain", dr[0], 0);
        chk("m_zero_bb", best_bid, 30);
        cmd(OP_CXL, 0, 30, 4);
        wait_idle();

        // cancels: non-best, then over-cancel of the best
        cmd(OP_ADD, 0, 100, 5);
        cmd(OP_ADD, 0, 90, 3);
        cmd(OP_CXL, 0, 90, 3);
        chk("cxl_nonbest_ready", in_ready, 1);
        chk("cxl_nonbest_bb", best_bid, 100);
        cmd(OP_CXL, 0, 100, 7);
        chk("cxl_over_err", err, 1);
        chk("cxl_over_ready", in_ready, 0);
        wait_idle();
        chk("cxl_over_bbv", best_bid_valid, 0);
        clr_log();
        cmd(OP_ADD, 0, 100, 1);
        cmd(OP_MATCH, 1, 0, 5);
        wait_done(1); wait_idle();
        chk("cxl_level_cleared_nfill", fp.size(), 1);
        chk("cxl_level_cleared_qty", fq[0], 1);
        chk("cxl_level_cleared_remain", dr[0], 4);

        // saturation, reserved op, zero add
        cmd(OP_ADD, 1, 10, 32'hFFFF_FFFF);
        chk("sat1_err", err, 0);
        chk("sat1_ba", best_ask, 10);
        cmd(OP_ADD, 1, 10, 32'hFFFF_FFFF);
        chk("sat2_err", err, 1);
        cmd(OP_RSV, 0, 0, 0);
        chk("rsv_err", err, 1);
        chk("rsv_ba", best_ask, 10);
        chk("rsv_bbv", best_bid_valid, 0);
        @(posedge clk); #1;
        chk("err_one_cycle", err, 0);
        cmd(OP_ADD, 0, 5, 0);
        chk("zero_add_bbv", best_bid_valid, 0);
        chk("zero_add_err", err, 0);
        clr_log();
        cmd(OP_MATCH, 0, 10, 32'hFFFF_FFFF);
        wait_done(1); wait_idle();
        chk("sat_level_qty", fq[0], 64'hFFFF_FFFF);
        chk("sat_level_price", fp[0], 10);
        chk("sat_level_remain", dr[0], 0);

        // reset in the middle of a match
        cmd(OP_ADD, 1, 20, 5);
        cmd(OP_ADD, 1, 21, 5);
        clr_log();
        cmd(OP_MATCH, 0, 30, 100);
        @(posedge clk); #1;
        chk("rmid_fill_seen", fill_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("rmid_ready", in_ready, 1);
        chk("rmid_fill_valid", fill_valid, 0);
        chk("rmid_fill_qty", fill_qty, 0);
        chk("rmid_fill_price", fill_price, 0);
        chk("rmid_bav", best_ask_valid, 0);
        chk("rmid_ba", best_ask, 0);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rmid_no_done", dr.size(), 0);
        chk("rmid_bbv", best_bid_valid, 0);
        clr_log();
        cmd(OP_MATCH, 0, 255, 3);
        wait_done(1);
        chk("rmid_empty_nfill", fp.size(), 0);
        chk("rmid_empty_remain", dr[0], 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
